axi_bridge_ip_tx: RTL and testbench

Egress up-sizer in core_clk domain: consumes IF_W Client-IF segments from Protocol (cl_rx_*) and packs them into DATA_W AXI-Stream beats to the IP (m_axis_*). Fills the egress slot of the AXI bridge top, mirroring the ingress down-sizer. Checks SOP/EOP framing and keep legality, and keeps RX telemetry.

---
 rtl/axi_bridge_pkg.sv | 28 ++
 rtl/axi_bridge_rx_pack.sv | 98 +++++++++
 rtl/axi_bridge_ip_tx.sv | 128 ++++++++++++
 tb/tb_axi_bridge_ip_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// rtl/axi_bridge_pkg.sv - shared types, widths and keep helpers for the AXI bridge
package axi_bridge_pkg;

    localparam int DEFAULT_DATA_W  = 256;
    localparam int DEFAULT_IF_W    = 64;
    localparam int DEFAULT_TUSER_W = 16;
    localparam int KEEP_MAX_W      = 128;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } fsm_state_e;

    // Non-zero and of the form 2^n-1: bytes valid from the LSB with no holes.
    function automatic logic is_contig_keep(input logic [KEEP_MAX_W-1:0] keep);
        return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
    endfunction

    function automatic logic [31:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            cnt = cnt + 32'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_bridge_rx_pack.sv
// rtl/axi_bridge_rx_pack.sv - segment slot counter, accumulator and output beat register
module axi_bridge_rx_pack
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int IF_W    = DEFAULT_IF_W,
    parameter int TUSER_W = DEFAULT_TUSER_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                seg_valid_i,
    input  logic                seg_first_i,
    input  logic                seg_last_i,
    input  logic [IF_W-1:0]     seg_data_i,
    input  logic [IF_W/8-1:0]   seg_keep_i,
    input  logic [TUSER_W-1:0]  seg_user_i,
    input  logic                out_ready_i,
    output logic [DATA_W-1:0]   out_data_o,
    output logic [DATA_W/8-1:0] out_keep_o,
    output logic [TUSER_W-1:0]  out_user_o,
    output logic                out_valid_o,
    output logic                out_last_o
);
    localparam int RATIO  = DATA_W / IF_W;
    localparam int SEG_KW = IF_W / 8;
    localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [SLOT_W-1:0]   slot_q, slot_d, base_slot;
    logic [DATA_W-1:0]   acc_data_q, acc_data_d, merged_data;
    logic [DATA_W/8-1:0] acc_keep_q, acc_keep_d, merged_keep;
    logic                complete;

    logic [DATA_W-1:0]   out_data_q;
    logic [DATA_W/8-1:0] out_keep_q;
    logic [TUSER_W-1:0]  out_user_q;
    logic                out_valid_q, out_last_q;

    // A first segment restarts at slot 0 and discards whatever was accumulated.
    always_comb begin
        base_slot   = seg_first_i ? '0 : slot_q;
        merged_data = seg_first_i ? '0 : acc_data_q;
        merged_keep = seg_first_i ? '0 : acc_keep_q;
        for (int k = 0; k < RATIO; k++) begin
            if (base_slot == SLOT_W'(k)) begin
                merged_data[k*IF_W +: IF_W]     = seg_data_i;
                merged_keep[k*SEG_KW +: SEG_KW] = seg_keep_i;
            end
        end
        complete   = seg_last_i || (base_slot == SLOT_W'(RATIO - 1));
        slot_d     = slot_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        if (seg_valid_i) begin
            if (complete) begin
                slot_d     = '0;
                acc_data_d = '0;
                acc_keep_d = '0;
            end else begin
                slot_d     = base_slot + SLOT_W'(1);
                acc_data_d = merged_data;
                acc_keep_d = merged_keep;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q      <= '0;
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            if (seg_valid_i && complete) begin
                out_valid_q <= 1'b1;
                out_data_q  <= merged_data;
                out_keep_q  <= merged_keep;
                out_user_q  <= seg_user_i;
                out_last_q  <= seg_last_i;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_keep_o  = out_keep_q;
    assign out_user_o  = out_user_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;

endmodule

// File: rtl/axi_bridge_ip_tx.sv
// rtl/axi_bridge_ip_tx.sv - egress up-sizer from Client-IF segments to AXI-Stream beats
module axi_bridge_ip_tx
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int IF_W    = DEFAULT_IF_W,
    parameter int TUSER_W = DEFAULT_TUSER_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IF_W-1:0]     cl_rx_data,
    input  logic [IF_W/8-1:0]   cl_rx_keep,
    input  logic [TUSER_W-1:0]  cl_rx_user,
    input  logic                cl_rx_valid,
    input  logic                cl_rx_sop,
    input  logic                cl_rx_eop,
    output logic                cl_rx_ready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic [TUSER_W-1:0]  m_axis_tuser,
    output logic                m_axis_tvalid,
    output logic                m_axis_tlast,
    input  logic                m_axis_tready,
    input  logic                bridge_enable,
    input  logic                strict_tkeep_en,
    output logic [31:0]         stat_rx_frames,
    output logic [31:0]         stat_rx_bytes,
    output logic [31:0]         stat_rx_stall_cycles,
    output logic                ev_err_tkeep_illegal,
    output logic                ev_err_sop_unexpected,
    output logic                ev_err_orphan_seg
);
    fsm_state_e         state_q;
    logic [TUSER_W-1:0] user_q;
    logic               seg_acc, seg_place, keep_bad, beat_hs;
    logic               ev_keep_q, ev_sop_q, ev_orphan_q;
    logic [31:0]        frames_q, frames_d, bytes_q, bytes_d, stall_q, stall_d;

    // Ready drops combinationally when the output beat is stuck, so no segment is ever lost.
    assign cl_rx_ready = bridge_enable && !(m_axis_tvalid && !m_axis_tready);
    assign seg_acc     = cl_rx_valid && cl_rx_ready;
    assign seg_place   = seg_acc && (cl_rx_sop || state_q == IN_PKT);
    assign beat_hs     = m_axis_tvalid && m_axis_tready;

    always_comb begin
        keep_bad = 1'b0;
        if (strict_tkeep_en && seg_place) begin
            if (cl_rx_eop) begin
                keep_bad = !is_contig_keep(KEEP_MAX_W'(cl_rx_keep));
            end else begin
                keep_bad = !(&cl_rx_keep);
            end
        end
    end

    always_comb begin
        frames_d = frames_q;
        bytes_d  = bytes_q;
        stall_d  = stall_q;
        if (beat_hs) begin
            frames_d = frames_q + 32'(m_axis_tlast);
            bytes_d  = bytes_q + popcount_keep(KEEP_MAX_W'(m_axis_tkeep));
        end
        if (m_axis_tvalid && !m_axis_tready) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            user_q      <= '0;
            ev_keep_q   <= 1'b0;
            ev_sop_q    <= 1'b0;
            ev_orphan_q <= 1'b0;
            frames_q    <= '0;
            bytes_q     <= '0;
            stall_q     <= '0;
        end else begin
            ev_keep_q   <= keep_bad;
            ev_sop_q    <= 1'b0;
            ev_orphan_q <= 1'b0;
            frames_q    <= frames_d;
            bytes_q     <= bytes_d;
            stall_q     <= stall_d;
            if (seg_acc) begin
                if (cl_rx_sop) begin
                    ev_sop_q <= (state_q == IN_PKT);
                    user_q   <= cl_rx_user;
                    state_q  <= cl_rx_eop ? IDLE : IN_PKT;
                end else if (state_q == IDLE) begin
                    ev_orphan_q <= 1'b1;
                end else if (cl_rx_eop) begin
                    state_q <= IDLE;
                end
            end
        end
    end

    axi_bridge_rx_pack #(
        .DATA_W  (DATA_W),
        .IF_W    (IF_W),
        .TUSER_W (TUSER_W)
    ) u_pack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .seg_valid_i (seg_place),
        .seg_first_i (cl_rx_sop),
        .seg_last_i  (cl_rx_eop),
        .seg_data_i  (cl_rx_data),
        .seg_keep_i  (cl_rx_keep),
        .seg_user_i  (cl_rx_sop ? cl_rx_user : user_q),
        .out_ready_i (m_axis_tready),
        .out_data_o  (m_axis_tdata),
        .out_keep_o  (m_axis_tkeep),
        .out_user_o  (m_axis_tuser),
        .out_valid_o (m_axis_tvalid),
        .out_last_o  (m_axis_tlast)
    );

    assign stat_rx_frames        = frames_q;
    assign stat_rx_bytes         = bytes_q;
    assign stat_rx_stall_cycles  = stall_q;
    assign ev_err_tkeep_illegal  = ev_keep_q;
    assign ev_err_sop_unexpected = ev_sop_q;
    assign ev_err_orphan_seg     = ev_orphan_q;

endmodule

// File: tb/tb_axi_bridge_ip_tx.sv
// tb/tb_axi_bridge_ip_tx.sv - randomized self-checking bench with a packet-level reference model
module tb_axi_bridge_ip_tx;
    localparam int DATA_W = 256;
    localparam int IF_W   = 64;
    localparam int RATIO  = DATA_W / IF_W;

    logic clk = 1'b0;
    logic rst_i, cl_rx_valid, cl_rx_sop, cl_rx_eop, cl_rx_ready;
    logic [63:0] cl_rx_data;
    logic [7:0] cl_rx_keep;
    logic [15:0] cl_rx_user, m_axis_tuser;
    logic [255:0] m_axis_tdata;
    logic [31:0] m_axis_tkeep, stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles;
    logic m_axis_tvalid, m_axis_tlast, m_axis_tready, bridge_enable, strict_tkeep_en;
    logic ev_err_tkeep_illegal, ev_err_sop_unexpected, ev_err_orphan_seg;

    always #5 clk = ~clk;

    axi_bridge_ip_tx dut (
        .clk_i(clk), .rst_i(rst_i),
        .cl_rx_data(cl_rx_data), .cl_rx_keep(cl_rx_keep), .cl_rx_user(cl_rx_user),
        .cl_rx_valid(cl_rx_valid), .cl_rx_sop(cl_rx_sop), .cl_rx_eop(cl_rx_eop),
        .cl_rx_ready(cl_rx_ready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .bridge_enable(bridge_enable), .strict_tkeep_en(strict_tkeep_en),
        .stat_rx_frames(stat_rx_frames), .stat_rx_bytes(stat_rx_bytes),
        .stat_rx_stall_cycles(stat_rx_stall_cycles),
        .ev_err_tkeep_illegal(ev_err_tkeep_illegal),
        .ev_err_sop_unexpected(ev_err_sop_unexpected),
        .ev_err_orphan_seg(ev_err_orphan_seg)
    );

    int n_pass = 0, n_total = 0;
    bit armed = 0;

    // Reference model: open packet as a list of segments, plus the pending output beat.
    bit m_in, m_ov, m_ol, m_zero, m_ek, m_es, m_eo;
    logic [63:0] m_sd [RATIO];
    logic [7:0]  m_sk [RATIO];
    int m_n;
    logic [15:0] m_user, m_ou;
    logic [255:0] m_od;
    logic [31:0] m_ok, m_fr, m_by, m_st;

    int ncap, n_sop_err, n_orph, n_keep_err;
    logic [255:0] cap_data [8];
    logic [31:0]  cap_keep [8];
    logic [15:0]  cap_user [8];
    bit           cap_last [8];

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endfunction

    function automatic void model_step(input bit v, sop, eop, input logic [63:0] d,
                                       input logic [7:0] k, input logic [15:0] u,
                                       input bit trdy, en, strict, rs);
        bit acc, take;
        if (rs) begin
            m_in = 0; m_ov = 0; m_ol = 0; m_n = 0; m_user = '0; m_ou = '0;
            m_od = '0; m_ok = '0; m_fr = '0; m_by = '0; m_st = '0;
            m_ek = 0; m_es = 0; m_eo = 0; m_zero = 1;
            return;
        end
        m_zero = 0;
        acc = v && en && !(m_ov && !trdy);
        m_ek = 0; m_es = 0; m_eo = 0;
        if (m_ov && !trdy) m_st++;
        if (m_ov && trdy) begin
            m_fr += 32'(m_ol);
            m_by += 32'($countones(m_ok));
            m_ov = 0;
        end
        if (acc) begin
            take = 0;
            if (sop) begin
                m_es = m_in; m_n = 0; m_user = u; m_in = 1; take = 1;
            end else if (!m_in) begin
                m_eo = 1;
            end else begin
                take = 1;
            end
            if (take) begin
                if (strict)
                    m_ek = eop ? !(k != 0 && int'(k) == (1 << $countones(k)) - 1) : (k != 8'hFF);
                m_sd[m_n] = d; m_sk[m_n] = k; m_n++;
                if (eop || m_n == RATIO) begin
                    m_od = '0; m_ok = '0;
                    for (int i = 0; i < m_n; i++) begin
                        m_od[i*64 +: 64] = m_sd[i];
                        m_ok[i*8 +: 8]   = m_sk[i];
                    end
                    m_ov = 1; m_ol = eop; m_ou = m_user; m_n = 0;
                    if (eop) m_in = 0;
                end
            end
        end
    endfunction

    task automatic cycle(input bit v, sop, eop, input logic [63:0] d, input logic [7:0] k,
                         input logic [15:0] u, input bit trdy, en, strict, rs);
        cl_rx_valid = v; cl_rx_sop = sop; cl_rx_eop = eop; cl_rx_data = d; cl_rx_keep = k;
        cl_rx_user = u; m_axis_tready = trdy; bridge_enable = en; strict_tkeep_en = strict;
        rst_i = rs;
        #2;
        if (armed) begin
            chk("cl_rx_ready", cl_rx_ready, en && !(m_ov && !trdy));
            chk("tvalid", m_axis_tvalid, m_ov);
            if (m_ov || m_zero) begin
                chk("tdata", m_axis_tdata, m_od);
                chk("tkeep", m_axis_tkeep, m_ok);
                chk("tuser", m_axis_tuser, m_ou);
                chk("tlast", m_axis_tlast, m_ol);
            end
            chk("ev_tkeep", ev_err_tkeep_illegal, m_ek);
            chk("ev_sop", ev_err_sop_unexpected, m_es);
            chk("ev_orphan", ev_err_orphan_seg, m_eo);
            chk("stat_frames", stat_rx_frames, m_fr);
            chk("stat_bytes", stat_rx_bytes, m_by);
            chk("stat_stall", stat_rx_stall_cycles, m_st);
            if (m_axis_tvalid && m_axis_tready && ncap < 8) begin
                cap_data[ncap] = m_axis_tdata; cap_keep[ncap] = m_axis_tkeep;
                cap_user[ncap] = m_axis_tuser; cap_last[ncap] = m_axis_tlast;
                ncap++;
            end
            if (ev_err_sop_unexpected) n_sop_err++;
            if (ev_err_orphan_seg) n_orph++;
            if (ev_err_tkeep_illegal) n_keep_err++;
        end
        model_step(v, sop, eop, d, k, u, trdy, en, strict, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input bit sop, eop, input logic [63:0] d, input logic [7:0] k,
                       input logic [15:0] u);
        cycle(1, sop, eop, d, k, u, 1, 1, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, '0, 1, 1, 1, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, '0, '0, '0, 1, 1, 1, 1);
        armed = 1;
        ncap = 0; n_sop_err = 0; n_orph = 0; n_keep_err = 0;
    endtask

    initial begin
        bit v, sop, eop, trdy, en, strict, rs;
        logic [7:0] k;
        int r;

        // Full 8-segment packet: two full beats, tlast on the second.
        do_reset();
        for (int i = 0; i < 8; i++) seg(i == 0, i == 7, {$urandom, $urandom}, 8'hFF, 16'h00A5);
        idle(2);
        chk("t1_nbeats", 32'(ncap), 32'd2);
        chk("t1_keep0", cap_keep[0], 32'hFFFF_FFFF);
        chk("t1_last0", cap_last[0], 1'b0);
        chk("t1_last1", cap_last[1], 1'b1);
        chk("t1_user1", cap_user[1], 16'h00A5);
        chk("t1_frames", stat_rx_frames, 32'd1);
        chk("t1_bytes", stat_rx_bytes, 32'd64);

        // Three segments with a short EOP: one partial beat.
        do_reset();
        seg(1, 0, 64'h1111_1111_1111_1111, 8'hFF, 16'h0001);
        seg(0, 0, 64'h2222_2222_2222_2222, 8'hFF, 16'h0002);
        seg(0, 1, 64'h3333_3333_3333_3333, 8'h0F, 16'h0003);
        idle(2);
        chk("t2_nbeats", 32'(ncap), 32'd1);
        chk("t2_keep", cap_keep[0], 32'h000F_FFFF);
        chk("t2_last", cap_last[0], 1'b1);
        chk("t2_upper", cap_data[0][255:192], 64'd0);
        chk("t2_user", cap_user[0], 16'h0001);
        chk("t2_bytes", stat_rx_bytes, 32'd20);

        // Back-pressure for five cycles with a segment waiting.
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1, i == 0, 0, {$urandom, $urandom}, 8'hFF, 16'h0BEE, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            cycle(1, 0, 1, 64'h5555_5555_5555_5555, 8'hFF, 16'h0, 0, 1, 1, 0);
        cycle(1, 0, 1, 64'h5555_5555_5555_5555, 8'hFF, 16'h0, 1, 1, 1, 0);
        idle(3);
        chk("t3_stall", stat_rx_stall_cycles, 32'd5);
        chk("t3_nbeats", 32'(ncap), 32'd2);
        chk("t3_bytes", stat_rx_bytes, 32'd40);
        chk("t3_seg5", cap_data[1][63:0], 64'h5555_5555_5555_5555);

        // Unexpected SOP aborts the first packet.
        do_reset();
        seg(1, 0, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 16'h0011);
        seg(1, 1, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 16'h0022);
        idle(2);
        chk("t4_sop_err", 32'(n_sop_err), 32'd1);
        chk("t4_nbeats", 32'(ncap), 32'd1);
        chk("t4_user", cap_user[0], 16'h0022);
        chk("t4_keep", cap_keep[0], 32'h0000_00FF);

        // Orphan segment, then illegal EOP keep still forwarded.
        do_reset();
        seg(0, 0, 64'hCCCC, 8'hFF, 16'h0);
        idle(1);
        chk("t5_orphan", 32'(n_orph), 32'd1);
        chk("t5_no_beat", 32'(ncap), 32'd0);
        seg(1, 1, 64'hDDDD, 8'h05, 16'h0033);
        idle(2);
        chk("t5_keep_err", 32'(n_keep_err), 32'd1);
        chk("t5_keep", cap_keep[0], 32'h0000_0005);

        // Reset after two segments, then a clean packet.
        do_reset();
        seg(1, 0, 64'hEEEE_EEEE_EEEE_EEEE, 8'hFF, 16'h0044);
        seg(0, 0, 64'hEEEE_EEEE_EEEE_EEEE, 8'hFF, 16'h0044);
        do_reset();
        chk("t6_tvalid", m_axis_tvalid, 1'b0);
        chk("t6_tdata", m_axis_tdata, 256'd0);
        seg(1, 0, 64'h1111_1111_1111_1111, 8'hFF, 16'h0055);
        seg(0, 0, 64'h2222_2222_2222_2222, 8'hFF, 16'h0055);
        seg(0, 0, 64'h3333_3333_3333_3333, 8'hFF, 16'h0055);
        seg(0, 1, 64'h4444_4444_4444_4444, 8'hFF, 16'h0055);
        idle(2);
        chk("t6_nbeats", 32'(ncap), 32'd1);
        chk("t6_data", cap_data[0],
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("t6_frames", stat_rx_frames, 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rs     = ($urandom % 400) == 0;
            en     = ($urandom % 10) != 0;
            strict = $urandom % 2;
            trdy   = ($urandom % 4) != 0;
            v      = ($urandom % 4) != 0;
            sop    = m_in ? (($urandom % 20) == 0) : (($urandom % 8) != 0);
            eop    = ($urandom % 5) == 0;
            r      = $urandom % 8;
            if (r < 6) k = 8'hFF;
            else if (r == 6) k = 8'((1 << $urandom_range(1, 8)) - 1);
            else k = 8'($urandom);
            cycle(v, sop, eop, {$urandom, $urandom}, k, 16'($urandom), trdy, en, strict, rs);
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
